// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
//   op encodings   : MULT/MULTU/DIV/DIVU as presented on op
//   state encodings: sequencer states of hilo_muldiv
//   defaults       : operand width and iteration-counter width
package hilo_muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage : hilo_muldiv_pkg

// File: rtl/hilo_muldiv_iter.sv
// One iteration of the unsigned magnitude datapath (purely combinational).
//   is_div_i  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi_i  : upper accumulator (partial product high / partial remainder)
//   acc_lo_i  : lower accumulator (multiplier bits / dividend-quotient bits)
//   opnd_i    : multiplicand (multiply) or divisor (divide) magnitude
//   nxt_hi_c  : upper accumulator after this step
//   nxt_lo_c  : lower accumulator after this step
module hilo_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] nxt_hi_c,
  output logic [WIDTH-1:0] nxt_lo_c
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Multiply: add multiplicand when the current multiplier LSB is set,
  // then shift the whole 2*WIDTH product right by one.
  // Divide: shift remainder:dividend left by one, trial-subtract the divisor
  // and keep the difference only when it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
    div_shift = {acc_hi_i, acc_lo_i[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_i};
    nxt_hi_c  = mul_sum[WIDTH:1];
    nxt_lo_c  = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!div_diff[WIDTH]) begin
        nxt_hi_c = div_diff[WIDTH-1:0];
        nxt_lo_c = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi_c = div_shift[WIDTH-1:0];
        nxt_lo_c = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule : hilo_muldiv_iter

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
//   clk, rst_n : core clock, asynchronous active-low reset
//   start, op  : launch MULT/MULTU/DIV/DIVU on a (rs) and b (rt)
//   mthi, mtlo : write a into HI / LO when idle
//   mfhi, mflo : core reads HI / LO this cycle (stall only)
//   hi, lo     : HI / LO registers
//   busy       : operation in flight
//   done       : one-cycle pulse after HI/LO receive a result
//   stall      : combinational hold request to the core
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q,   opnd_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               is_div_q, is_div_d;
  logic               neg_q,    neg_d;     // product / quotient sign
  logic               rneg_q,   rneg_d;    // remainder sign
  logic               bzero_q,  bzero_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes: signed ops negate negative inputs.
  assign op_signed = ~op[0];
  assign a_mag = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  hilo_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .is_div_i (is_div_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .nxt_hi_c (iter_hi),
    .nxt_lo_c (iter_lo)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod     = {acc_hi_q, acc_lo_q};
    quo      = acc_lo_q;
    rem      = acc_hi_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Multiply keeps multiplier in acc_lo; divide keeps dividend there.
          is_div_d = op[1];
          neg_d    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = op_signed & a[WIDTH-1];
          bzero_d  = (b == '0);
          a_orig_d = a;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? a_mag : b_mag;
          opnd_d   = op[1] ? b_mag : a_mag;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end

      ST_CALC: begin
        // WIDTH iteration cycles, then one settle cycle at cnt == WIDTH.
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = ST_FIX;
        end else begin
          acc_hi_d = iter_hi;
          acc_lo_d = iter_lo;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          if (neg_q)  quo = ~acc_lo_q + WIDTH'(1);
          if (rneg_q) rem = ~acc_hi_q + WIDTH'(1);
          if (bzero_q) begin
            lo_d = '1;
            hi_d = a_orig_q;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else begin
          if (neg_q) prod = ~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1);
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  // Any core request that touches HI/LO must wait while an op is in flight.
  assign stall = busy & (start | mthi | mtlo | mfhi | mflo);

endmodule : hilo_muldiv

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: the driver queues expected HI/LO per
// accepted operation, the monitor pops and compares on every done pulse.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int unsigned W        = 32;
  localparam int unsigned LATENCY  = W + 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [7:0]   tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         mfhi = 1'b0;
  logic         mflo = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  hilo_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .mfhi  (mfhi),
    .mflo  (mflo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .stall (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Present one start request; optionally queue its expected result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic [7:0] tag);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    if (push) begin
      e.hi = eh; e.lo = el; e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until the in-flight op finishes, then confirm done is a single pulse.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, 64'(busy), 64'(0));
    @(negedge clk);
    check({name, "_done_single"}, 64'(done), 64'(0));
  endtask

  // Monitor: count busy cycles, compare results on each done pulse.
  initial begin : monitor
    int   busy_len;
    exp_t e;
    busy_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_len = 0;
      end else begin
        if (busy) busy_len++;
        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check($sformatf("op%0d_hi", e.tag), 64'(hi), 64'(e.hi));
            check($sformatf("op%0d_lo", e.tag), 64'(lo), 64'(e.lo));
            check($sformatf("op%0d_busy_len", e.tag), 64'(busy_len), 64'(LATENCY));
          end
          busy_len = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    check("rst_hi",    64'(hi),    64'(0));
    check("rst_lo",    64'(lo),    64'(0));
    check("rst_busy",  64'(busy),  64'(0));
    check("rst_done",  64'(done),  64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    rst_n = 1'b1;

    // Directed arithmetic vectors.
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 8'd1);
    wait_idle("mult_neg");
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 8'd2);
    wait_idle("multu");
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd3);
    wait_idle("div_neg");
    issue(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 8'd4);
    wait_idle("divu_zero");
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 8'd5);
    wait_idle("div_ovf");
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 8'd6);
    wait_idle("div_zero_neg");

    // Idle mthi/mtlo: no stall, written at the next edge.
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; a = 32'h0000_5555;
    #1 check("idle_stall", 64'(stall), 64'(0));
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_idle", 64'(hi), 64'h5555);
    check("mtlo_idle", 64'(lo), 64'h5555);

    // Requests during CALC stall and are dropped.
    issue(OP_MULT, 32'h0000_0006, 32'h0000_0007, 1'b1, 32'h0000_0000, 32'h0000_002A, 8'd7);
    repeat (2) @(negedge clk);
    mthi = 1'b1; a = 32'h0000_1234;
    #1 check("busy_mthi_stall", 64'(stall), 64'(1));
    @(negedge clk);
    mthi = 1'b0; mflo = 1'b1;
    #1 check("busy_mflo_stall", 64'(stall), 64'(1));
    check("busy_hi_held", 64'(hi), 64'h5555);
    @(negedge clk);
    mflo = 1'b0;
    #1 check("busy_nostall", 64'(stall), 64'(0));
    wait_idle("mult_stall");

    @(negedge clk);
    mthi = 1'b1; a = 32'h0000_1234;
    #1 check("post_mthi_stall", 64'(stall), 64'(0));
    @(negedge clk);
    mthi = 1'b0;
    check("post_mthi_hi", 64'(hi), 64'h1234);

    // Reset mid-operation aborts with no result.
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, '0, 8'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hi",   64'(hi),   64'(0));
    check("abort_lo",   64'(lo),   64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 8'd8);
    wait_idle("divu_after_rst");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hilo_muldiv
